pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit; next generation of the 16-bit PC register.
- Holds the current PC and selects the next PC from these sources: sequential, branch, jump/call, exception vector, exception return and return-address stack (RAS).
- Sits at the head of the fetch stage and drives the instruction-memory address.
- Adds stall, exception handling with EPC save/restore, alignment checking, and an optional call/return stack.

Parameters:
- WIDTH, 16: PC width in bits.
- STEP, 2: sequential increment in bytes; power of two, at least 1.
- RESET_VECTOR, 16'h0000: PC value loaded on reset.
- EXC_VECTOR, 16'h0004: PC value loaded on an exception request.
- RAS_DEPTH, 4: return-stack entries; power of two, at least 2; used only with PC_RAS_EN.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset; asynchronous, active-high.
- stall, input, 1: hold the PC; overridden by exc_req.
- branch_taken, input, 1: load branch_target.
- branch_target, input, WIDTH: branch destination.
- jump, input, 1: load jump_target.
- call, input, 1: load jump_target and push the return address.
- jump_target, input, WIDTH: jump/call destination.
- ret, input, 1: pop the RAS into the PC.
- exc_req, input, 1: take the exception.
- eret, input, 1: return to EPC.
- pc_out, output, WIDTH: current PC (registered).
- pc_seq, output, WIDTH: pc_out + STEP (combinational; return-address value).
- epc_out, output, WIDTH: saved exception PC.
- align_err, output, 1: one-cycle pulse when a loaded target was misaligned.
- ras_empty, output, 1: RAS holds no entries.
- ras_underflow, output, 1: one-cycle pulse when ret is accepted with an empty RAS.

Behaviour:
- Reset (asynchronous, immediate on rst rising):
  - pc_out = RESET_VECTOR, epc_out = 0.
  - align_err = 0, ras_underflow = 0.
  - RAS pointer and count = 0, so ras_empty = 1.
  - Reset asserted mid-operation discards all pending state, including RAS contents.
- Update timing: the PC updates on each rising clk edge. The new value appears one cycle after the controls are sampled; there is no other latency.
- Priority, highest first:
  1. exc_req: pc = EXC_VECTOR; epc = pc_out. Honoured even when stall = 1.
  2. stall: hold pc, epc and RAS. All other controls are ignored; no pulses are generated.
  3. eret: pc = epc_out.
  4. ret: pc = RAS top; pop.
  5. branch_taken: pc = branch_target.
  6. call: pc = jump_target; push pc_seq.
  7. jump: pc = jump_target.
  8. Otherwise: pc = pc_seq.
- Only the winning source acts. A losing call does not push and a losing ret does not pop.
- Arithmetic: pc_seq = (pc_out + STEP) modulo 2^WIDTH. Example: 16'hFFFE + 2 = 16'h0000, with no flag.
- Alignment:
  - Applies to branch_target and jump_target when loaded (this includes call).
  - Low log2(STEP) bits are forced to 0 before loading.
  - If any of those bits was 1, align_err = 1 in the cycle after the load.
  - STEP = 1 never flags.
- Exception sources:
  - EXC_VECTOR and epc are loaded unchanged; no alignment check.
  - exc_req while already at the vector overwrites epc with the current pc_out (no nesting).
- RAS (PC_RAS_EN):
  - Circular buffer of RAS_DEPTH entries with a count saturating at RAS_DEPTH.
  - Push when full: overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop: returns the most recent entry; count decrements.
  - ret with an empty RAS: pc = pc_seq, ras_underflow = 1 for one cycle, count stays 0.
  - call and ret in the same cycle: ret wins (priority); no push.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: the RAS exists as specified above.
- Undefined:
  - No RAS storage is built.
  - ret is treated as absent; the PC follows the next-lower priority source.
  - call behaves as jump (no push).
  - ras_empty is tied to 1 and ras_underflow is tied to 0.

Test Plan:
- Reset and sequence (WIDTH=16, STEP=2): hold rst for 5 cycles → pc_out = 16'h0000. Release rst → pc_out = 2, 4, 6, 8 on successive edges. Assert rst mid-cycle at pc = 8 → pc_out = 0 immediately.
- Stall and priority:
  - At pc = 16'h0010, assert stall for 3 cycles → pc_out holds 16'h0010.
  - stall with branch_taken (target 16'h0100) → pc_out holds.
  - branch_taken and jump together (targets 16'h0100 / 16'h0200) → pc_out = 16'h0100.
- Exception round-trip: at pc = 16'h0020, assert exc_req with stall = 1 → pc_out = 16'h0004, epc_out = 16'h0020. Run 2 cycles, then assert eret → pc_out = 16'h0020.
- Alignment and wrap:
  - jump to 16'h0033 → pc_out = 16'h0032, align_err pulses for one cycle.
  - At pc = 16'hFFFE with no control → pc_out = 16'h0000, align_err = 0.
- RAS with PC_RAS_EN, RAS_DEPTH=4:
  - call at 16'h0010 → 16'h0100; call → 16'h0200; ret → 16'h0102; ret → 16'h0012; ras_empty = 1.
  - 5 calls, then 5 rets → first 4 rets return the newest 4 entries; 5th ret gives pc_seq with ras_underflow = 1.
- Without PC_RAS_EN: call to 16'h0100 → pc_out = 16'h0100. Then ret → pc_out = 16'h0102. ras_empty = 1 throughout.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: stall, exception entry/return, target alignment.
// Define PC_RAS_EN to build the return-address stack used by call/ret.
module pc_unit #(
  parameter int               WIDTH        = 16,
  parameter int               STEP         = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(4),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic [WIDTH-1:0] epc_out,
  output logic             align_err,
  output logic             ras_empty,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             align_q, align_d;

  assign pc_seq    = pc_q + STEP_W;
  assign pc_out    = pc_q;
  assign epc_out   = epc_q;
  assign align_err = align_q;

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             unf_q, unf_d;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;

  // ptr_q is the next write slot; the newest entry sits just below it
  assign ras_top       = ras_q[ptr_q - PTR_W'(1)];
  assign ras_empty     = (cnt_q == '0);
  assign ras_underflow = unf_q;
`else
  logic unused_ret;
  assign unused_ret    = ret;
  assign ras_empty     = 1'b1;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_seq;
    epc_d   = epc_q;
    align_d = 1'b0;
`ifdef PC_RAS_EN
    unf_d    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    if (exc_req) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret) begin
      pc_d = epc_q;
    end
`ifdef PC_RAS_EN
    else if (ret) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d    = ras_top;
        ras_pop = 1'b1;
      end
    end
`endif
    else if (branch_taken) begin
      pc_d    = branch_target & ~ALIGN_MASK;
      align_d = |(branch_target & ALIGN_MASK);
    end else if (call || jump) begin
      pc_d    = jump_target & ~ALIGN_MASK;
      align_d = |(jump_target & ALIGN_MASK);
`ifdef PC_RAS_EN
      ras_push = call;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      align_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      align_q <= align_d;
    end
  end

`ifdef PC_RAS_EN
  // Circular buffer: a push when full overwrites the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      unf_q <= unf_d;
      if (ras_push) begin
        ras_q[ptr_q] <= pc_seq;
        ptr_q        <= ptr_q + PTR_W'(1);
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + (PTR_W + 1)'(1);
      end else if (ras_pop) begin
        ptr_q <= ptr_q - PTR_W'(1);
        cnt_q <= cnt_q - (PTR_W + 1)'(1);
      end
    end
  end
`endif

endmodule
